// File: rtl/plab2_proc_bypass_scoreboard_pkg.sv
// rtl/plab2_proc_bypass_scoreboard_pkg.sv - shared constants and readiness rule for the bypass scoreboard
package plab2_proc_bypass_scoreboard_pkg;

  localparam int BYP_SEL_RF = 0;

  localparam int DEF_NREGS   = 32;
  localparam int DEF_NSRCS   = 2;
  localparam int DEF_NSTAGES = 3;

  // A producer in slot k is bypassable once k reaches its avail index; a
  // variable-latency op sitting in X is only ready when its unit says so.
  function automatic logic slot_ready(input int k, input int avail,
                                      input logic is_long, input logic long_done);
    return (is_long && k == 0) ? long_done : (k >= avail);
  endfunction

endpackage

// File: rtl/plab2_proc_bypass_scoreboard_slot.sv
// rtl/plab2_proc_bypass_scoreboard_slot.sv - one in-flight writer tag slot with load/hold/bubble
module plab2_proc_bypass_scoreboard_slot
  import plab2_proc_bypass_scoreboard_pkg::*;
#(
  parameter int AW = 5,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          clr,
  input  logic          in_val,
  input  logic          in_wen,
  input  logic [AW-1:0] in_waddr,
  input  logic [SW-1:0] in_avail,
  input  logic          in_long,
  output logic          val,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [SW-1:0] avail,
  output logic          long_op
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val     <= 1'b0;
      wen     <= 1'b0;
      waddr   <= '0;
      avail   <= '0;
      long_op <= 1'b0;
    end else if (clr) begin
      val <= 1'b0;
    end else if (ld) begin
      val     <= in_val;
      wen     <= in_wen;
      waddr   <= in_waddr;
      avail   <= in_avail;
      long_op <= in_long;
    end
  end

endmodule

// File: rtl/plab2_proc_bypass_scoreboard.sv
// rtl/plab2_proc_bypass_scoreboard.sv - N-stage bypass/stall scoreboard; PLAB2_PROC_BYP_SB_PERF_EN adds perf counters
module plab2_proc_bypass_scoreboard
  import plab2_proc_bypass_scoreboard_pkg::*;
#(
  parameter int p_nregs   = DEF_NREGS,
  parameter int p_nsrcs   = DEF_NSRCS,
  parameter int p_nstages = DEF_NSTAGES,
  localparam int AW = $clog2(p_nregs),
  localparam int SW = $clog2(p_nstages + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sd,
  input  logic                   iss_val,
  input  logic                   iss_wen,
  input  logic [AW-1:0]          iss_waddr,
  input  logic [SW-1:0]          iss_avail,
  input  logic                   iss_long,
  input  logic                   long_done,
  input  logic [p_nstages-1:0]   stage_en,
  input  logic                   squash_X,
  input  logic [p_nsrcs-1:0]     src_val,
  input  logic [p_nsrcs*AW-1:0]  src_addr,
  output logic [p_nsrcs*SW-1:0]  byp_sel,
  output logic                   stall_D,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_byp_cnt
);

  logic [p_nstages-1:0] s_val;
  logic [p_nstages-1:0] s_wen;
  logic [p_nstages-1:0] s_long;
  logic [AW-1:0]        s_waddr [p_nstages];
  logic [SW-1:0]        s_avail [p_nstages];
  logic [p_nsrcs-1:0]   src_stall;

  // sd is a label only; the W slot always drains, so its enable is not consulted.
  logic unused_ok;
  assign unused_ok = ^{sd, stage_en[p_nstages-1]};

  for (genvar k = 0; k < p_nstages; k++) begin : g_slot
    logic          ld, clr, in_val, in_wen, in_long;
    logic [AW-1:0] in_waddr;
    logic [SW-1:0] in_avail;

    if (k == 0) begin : g_x
      assign ld       = stage_en[0];
      assign clr      = squash_X;
      assign in_val   = iss_val & ~stall_D;
      assign in_wen   = iss_wen;
      assign in_waddr = iss_waddr;
      assign in_avail = iss_avail;
      assign in_long  = iss_long;
    end else begin : g_n
      assign ld       = stage_en[k-1];
      assign in_wen   = s_wen[k-1];
      assign in_waddr = s_waddr[k-1];
      assign in_avail = s_avail[k-1];
      assign in_long  = s_long[k-1];
      // A squashed X entry must not reappear in M.
      if (k == 1) begin : g_sq
        assign in_val = s_val[0] & ~squash_X;
      end else begin : g_pass
        assign in_val = s_val[k-1];
      end
      if (k == p_nstages - 1) begin : g_last
        assign clr = ~stage_en[k-1];
      end else begin : g_mid
        assign clr = ~stage_en[k-1] & stage_en[k];
      end
    end

    plab2_proc_bypass_scoreboard_slot #(.AW(AW), .SW(SW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .ld       (ld),
      .clr      (clr),
      .in_val   (in_val),
      .in_wen   (in_wen),
      .in_waddr (in_waddr),
      .in_avail (in_avail),
      .in_long  (in_long),
      .val      (s_val[k]),
      .wen      (s_wen[k]),
      .waddr    (s_waddr[k]),
      .avail    (s_avail[k]),
      .long_op  (s_long[k])
    );
  end

  // Oldest-to-youngest scan so the youngest matching producer wins.
  always_comb begin
    byp_sel   = '0;
    src_stall = '0;
    for (int s = 0; s < p_nsrcs; s++) begin
      byp_sel[s*SW +: SW] = SW'(BYP_SEL_RF);
      for (int k = p_nstages - 1; k >= 0; k--) begin
        if (src_val[s] && s_val[k] && s_wen[k] &&
            src_addr[s*AW +: AW] != '0 && s_waddr[k] == src_addr[s*AW +: AW]) begin
          byp_sel[s*SW +: SW] = SW'(k + 1);
          src_stall[s] = !slot_ready(k, int'(s_avail[k]), s_long[k], long_done);
        end
      end
    end
  end

  assign stall_D = |src_stall;

`ifdef PLAB2_PROC_BYP_SB_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] byp_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      byp_cnt   <= '0;
    end else begin
      if (stall_D && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (!stall_D && |byp_sel && byp_cnt != '1)
        byp_cnt <= byp_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_byp_cnt   = byp_cnt;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_byp_cnt   = 32'd0;
`endif

endmodule
